// File: rtl/nn_alu_pkg.sv
// Shared opcodes, FSM state type and the signed saturation helper for the sequential NN ALU.
package nn_alu_pkg;

  localparam logic [3:0] OP_SUM  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_RELU = 4'd7;
  localparam logic [3:0] OP_MAXP = 4'd8;
  localparam logic [3:0] OP_FC   = 4'd9;
  localparam logic [3:0] OP_CONV = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Clamp a signed value into the w-bit signed range.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate; load_i restarts the sum from bias_i instead of the held accumulator.
module mac_unit #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     en_i,
  input  logic                     load_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  input  logic signed [ACC_W-1:0]  bias_i,
  output logic signed [ACC_W-1:0]  sum_c
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_q;

  assign prod  = a_i * b_i;
  assign sum_c = (load_i ? bias_i : acc_q) + ACC_W'(prod);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_c;
    end
  end

endmodule

// File: rtl/nn_alu_seq.sv
// Sequential NN-extended ALU: single-cycle scalar ops, serial MaxPool/FC/Conv2d on one MAC.
module nn_alu_seq
  import nn_alu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned MAT_N  = 4,
  parameter int unsigned K_SIZE = 3,
  parameter int unsigned FC_IN  = 4,
  parameter int unsigned FC_OUT = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            start_i,
  input  logic [3:0]                      ALUCtrl_i,
  input  logic [31:0]                     data1_i,
  input  logic [31:0]                     data2_i,
  input  logic [DATA_W*MAT_N*MAT_N-1:0]   data_matrix_i,
  input  logic [DATA_W*MAT_N*MAT_N-1:0]   weight_matrix_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [31:0]                     data_o,
  output logic                            Zero_o
);

  localparam int unsigned OUT_N    = MAT_N - K_SIZE + 1;
  localparam int unsigned MAT_BITS = DATA_W * MAT_N * MAT_N;
  localparam int unsigned MP_N     = 32 / DATA_W;
  localparam int unsigned IDX_W    = 8;

  // Element e of a packed word / matrix, element 0 at the MSB.
  function automatic logic signed [DATA_W-1:0] word_el(input logic [31:0] w,
                                                       input int unsigned e);
    return w[31 - e*DATA_W -: DATA_W];
  endfunction

  function automatic logic signed [DATA_W-1:0] mat_el(input logic [MAT_BITS-1:0] m,
                                                      input int unsigned e);
    return m[MAT_BITS - 1 - e*DATA_W -: DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] sat_el(input logic signed [ACC_W-1:0] v);
    return DATA_W'(saturate(64'(v), DATA_W));
  endfunction

  state_e                   state_q, state_d;
  logic [3:0]               op_q;
  logic [31:0]              d1_q, d2_q, res_q, res_d, final_c;
  logic [MAT_BITS-1:0]      dm_q, wm_q;
  logic [IDX_W-1:0]         i_q, i_d, o_q, o_d, kr_q, kr_d, kc_q, kc_d, r_q, r_d, c_q, c_d;
  logic signed [DATA_W-1:0] max_q, max_d, el_c;
  logic                     accept;
  logic                     mac_en, mac_load;
  logic signed [DATA_W-1:0] mac_a, mac_b;
  logic signed [ACC_W-1:0]  mac_bias, mac_sum;

  mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (mac_en),
    .load_i  (mac_load),
    .a_i     (mac_a),
    .b_i     (mac_b),
    .bias_i  (mac_bias),
    .sum_c   (mac_sum)
  );

  // MAC operand selection from the current loop indices.
  always_comb begin
    mac_en   = 1'b0;
    mac_load = 1'b0;
    mac_a    = '0;
    mac_b    = '0;
    mac_bias = '0;
    if (state_q == ST_RUN && op_q == OP_FC) begin
      mac_en   = 1'b1;
      mac_load = (i_q == '0);
      mac_a    = word_el(d1_q, 32'(i_q));
      mac_b    = mat_el(wm_q, 32'(o_q) * FC_IN + 32'(i_q));
      mac_bias = ACC_W'(word_el(d2_q, 32'(o_q)));
    end else if (state_q == ST_RUN && op_q == OP_CONV) begin
      mac_en   = 1'b1;
      mac_load = (kr_q == '0) && (kc_q == '0);
      mac_a    = mat_el(dm_q, (32'(r_q) + 32'(kr_q)) * MAT_N + 32'(c_q) + 32'(kc_q));
      mac_b    = mat_el(wm_q, 32'(kr_q) * K_SIZE + 32'(kc_q));
      mac_bias = ACC_W'(word_el(d2_q, 32'd0));
    end
  end

  // Next state, loop counters and result assembly.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    o_d     = o_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    r_d     = r_q;
    c_d     = c_q;
    res_d   = res_q;
    max_d   = max_q;
    final_c = res_q;
    el_c    = '0;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = ST_RUN;
          i_d     = '0;
          o_d     = '0;
          kr_d    = '0;
          kc_d    = '0;
          r_d     = '0;
          c_d     = '0;
          res_d   = '0;
          max_d   = '0;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        case (op_q)
          OP_MAXP: begin
            el_c    = word_el(d1_q, 32'(i_q));
            max_d   = (i_q == '0 || el_c > max_q) ? el_c : max_q;
            i_d     = i_q + 1'b1;
            final_c = 32'(max_d);
            if (i_q == IDX_W'(MP_N - 1)) state_d = ST_DONE;
          end
          OP_FC: begin
            i_d = i_q + 1'b1;
            if (i_q == IDX_W'(FC_IN - 1)) begin
              res_d[31 - 32'(o_q)*DATA_W -: DATA_W] = sat_el(mac_sum);
              i_d = '0;
              o_d = o_q + 1'b1;
              if (o_q == IDX_W'(FC_OUT - 1)) state_d = ST_DONE;
            end
            final_c = res_d;
          end
          OP_CONV: begin
            kc_d = kc_q + 1'b1;
            if (kc_q == IDX_W'(K_SIZE - 1)) begin
              kc_d = '0;
              kr_d = kr_q + 1'b1;
              if (kr_q == IDX_W'(K_SIZE - 1)) begin
                kr_d = '0;
                res_d[31 - (32'(r_q)*OUT_N + 32'(c_q))*DATA_W -: DATA_W] = sat_el(mac_sum);
                c_d = c_q + 1'b1;
                if (c_q == IDX_W'(OUT_N - 1)) begin
                  c_d = '0;
                  r_d = r_q + 1'b1;
                  if (r_q == IDX_W'(OUT_N - 1)) state_d = ST_DONE;
                end
              end
            end
            final_c = res_d;
          end
          default: begin
            state_d = ST_DONE;
            case (op_q)
              OP_SUM:  final_c = d1_q + d2_q;
              OP_SUB:  final_c = d1_q - d2_q;
              OP_AND:  final_c = d1_q & d2_q;
              OP_OR:   final_c = d1_q | d2_q;
              OP_XOR:  final_c = d1_q ^ d2_q;
              OP_MUL:  final_c = d1_q * d2_q;
              OP_RELU: final_c = d1_q[31] ? '0 : d1_q;
              default: final_c = d1_q;
            endcase
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand latches and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      dm_q    <= '0;
      wm_q    <= '0;
      i_q     <= '0;
      o_q     <= '0;
      kr_q    <= '0;
      kc_q    <= '0;
      r_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      max_q   <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      data_o  <= '0;
      Zero_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      o_q     <= o_d;
      kr_q    <= kr_d;
      kc_q    <= kc_d;
      r_q     <= r_d;
      c_q     <= c_d;
      res_q   <= res_d;
      max_q   <= max_d;
      busy_o  <= (state_d == ST_RUN);
      done_o  <= (state_d == ST_DONE);
      if (accept) begin
        op_q <= ALUCtrl_i;
        d1_q <= data1_i;
        d2_q <= data2_i;
        dm_q <= data_matrix_i;
        wm_q <= weight_matrix_i;
      end
      if (state_q == ST_RUN && state_d == ST_DONE) begin
        data_o <= final_c;
        Zero_o <= (d1_q == d2_q);
      end
    end
  end

endmodule
